pc_unit: RTL

Parametrised program-counter unit for the single-issue RISC-V fetch stage. It holds the architectural fetch PC and selects the next PC from these sources: reset vector, execute-stage redirect, stall hold, return-address-stack prediction, or sequential PC+4. It sits between the control/execute redirect logic and instruction memory, and generalises the basic PC+4/PC+imm register with stall, absolute redirect, alignment checking and optional return prediction.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_ras.sv | 60 ++++++
 rtl/pc_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } next_pc_sel_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Compiled only when PC_RAS_EN is defined.
`ifdef PC_RAS_EN
module pc_ras #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic                  empty_o
);
  import pc_pkg::*;

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PtrW-1:0]       r_ptr;
  logic [CntW-1:0]       r_cnt;
  logic [PtrW-1:0]       w_top_ptr;
  logic                  w_pop_ok;

  // r_ptr is the next free slot; the top lives one below it.
  assign w_top_ptr = r_ptr - PtrW'(1);
  assign empty_o   = (r_cnt == '0);
  assign top_o     = r_mem[w_top_ptr];
  assign w_pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_pop_ok && !push_i) begin
      r_ptr <= w_top_ptr;
      r_cnt <= r_cnt - CntW'(1);
    end else if (push_i && !w_pop_ok) begin
      r_ptr <= r_ptr + PtrW'(1);
      if (r_cnt != CntW'(RAS_DEPTH)) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  // Pop plus push replaces the top in place.
  always_ff @(posedge clk) begin
    if (push_i) begin
      if (w_pop_ok) begin
        r_mem[w_top_ptr] <= push_data_i;
      end else begin
        r_mem[r_ptr] <= push_data_i;
      end
    end
  end

endmodule
`endif

// File: rtl/pc_unit.sv
// Fetch program counter: reset / redirect / hold / RAS prediction / PC+4.
// Return prediction is built only when PC_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  input  logic                  call_i,
  input  logic                  ret_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  pred_ret_o,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] w_ras_top;
  logic                  w_ras_hit;
  next_pc_sel_e          w_sel;

  assign pc_o       = r_pc;
  assign pc_plus4_o = r_pc + DATA_WIDTH'(INSTR_BYTES);
  assign misalign_o = r_misalign;

`ifdef PC_RAS_EN
  logic w_advance;
  logic w_ras_empty;
  logic r_pred_ret;

  assign w_advance = ~rst & ~redirect_i & ~stall_i;
  assign w_ras_hit = ret_i & ~w_ras_empty;

  pc_ras #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_advance & call_i),
    .pop_i       (w_advance & ret_i),
    .push_data_i (pc_plus4_o),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty)
  );

  // A held PC keeps its origin flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_ret <= 1'b0;
    end else if (w_sel != SEL_HOLD) begin
      r_pred_ret <= (w_sel == SEL_RAS);
    end
  end

  assign pred_ret_o = r_pred_ret;
`else
  logic        w_unused_pred;
  logic [31:0] w_unused_depth;

  assign w_ras_hit      = 1'b0;
  assign w_ras_top      = '0;
  assign pred_ret_o     = 1'b0;
  assign w_unused_pred  = call_i ^ ret_i;
  assign w_unused_depth = 32'(RAS_DEPTH);
`endif

  always_comb begin
    w_sel = SEL_SEQ;
    if (rst) begin
      w_sel = SEL_RESET;
    end else if (redirect_i) begin
      w_sel = SEL_REDIRECT;
    end else if (stall_i) begin
      w_sel = SEL_HOLD;
    end else if (w_ras_hit) begin
      w_sel = SEL_RAS;
    end
  end

  always_comb begin
    w_next_pc = pc_plus4_o;
    case (w_sel)
      SEL_RESET:    w_next_pc = RESET_VECTOR;
      SEL_REDIRECT: w_next_pc = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};
      SEL_HOLD:     w_next_pc = r_pc;
      SEL_RAS:      w_next_pc = w_ras_top;
      default:      w_next_pc = pc_plus4_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_misalign <= redirect_i & (redirect_target_i[1:0] != 2'b00);
    end
  end

endmodule
